am9513_ctx_bank: RTL

//   Parametrised per-context state bank for the Am9513 accelerator. Holds per context:
//   - IEEE rounding mode and sticky flags;
//   - scalar and vector register files;
//   - legacy LIFO stack.

---
 rtl/am9513_pkg.sv | 12 +
 rtl/carbon_arch_pkg.sv | 8 +
 rtl/am9513_ctx_stack.sv | 61 ++++++
 rtl/am9513_ctx_bank.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/am9513_pkg.sv
// am9513_pkg: shared types for the Am9513 context bank.
//   clr_state_e      : context-clear engine states
//   AM9513_NUM_FLAGS : number of sticky IEEE flags per context
package am9513_pkg;
  localparam int AM9513_NUM_FLAGS = 5;

  typedef enum logic [1:0] {
    CLR_IDLE,
    CLR_CLEAR,
    CLR_DONE
  } clr_state_e;
endpackage

// File: rtl/carbon_arch_pkg.sv
// carbon_arch_pkg: architecture-wide constants shared by the Carbon blocks.
// Only the IEEE rounding-mode encodings are needed by the Am9513 context bank.
package carbon_arch_pkg;
  localparam logic [1:0] CARBON_RND_RN = 2'd0;  // round to nearest even
  localparam logic [1:0] CARBON_RND_RZ = 2'd1;  // round toward zero
  localparam logic [1:0] CARBON_RND_RP = 2'd2;  // round toward +inf
  localparam logic [1:0] CARBON_RND_RM = 2'd3;  // round toward -inf
endpackage

// File: rtl/am9513_ctx_stack.sv
// am9513_ctx_stack: stack-pointer / LIFO update for the currently selected
// context. Purely combinational; the bank owns the storage.
// Ports:
//   push, pop     : operation requests (already qualified by the bank)
//   full, empty   : state of the selected context's stack
//   sp            : current stack pointer (entries in use)
//   sp_next       : stack pointer after the operation
//   wr_en/wr_addr : entry write strobe and address for push_data
//   ovf, unf      : overflow / underflow detected this cycle
module am9513_ctx_stack
  import am9513_pkg::*;
#(
  parameter int SP_W   = 5,
  parameter int ADDR_W = 4
) (
  input  logic              push,
  input  logic              pop,
  input  logic              full,
  input  logic              empty,
  input  logic [SP_W-1:0]   sp,
  output logic [SP_W-1:0]   sp_next,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              ovf,
  output logic              unf
);

  always_comb begin
    sp_next = sp;
    wr_en   = 1'b0;
    wr_addr = ADDR_W'(sp);
    ovf     = 1'b0;
    unf     = 1'b0;
    if (push && pop) begin
      // Simultaneous push+pop replaces the top; on an empty stack the pop
      // underflows but the push still lands in entry 0.
      wr_en = 1'b1;
      if (empty) begin
        unf     = 1'b1;
        wr_addr = '0;
        sp_next = SP_W'(1);
      end else begin
        wr_addr = ADDR_W'(sp - SP_W'(1));
      end
    end else if (push) begin
      if (full) begin
        ovf = 1'b1;
      end else begin
        wr_en   = 1'b1;
        sp_next = sp + SP_W'(1);
      end
    end else if (pop) begin
      if (empty) begin
        unf = 1'b1;
      end else begin
        sp_next = sp - SP_W'(1);
      end
    end
  end

endmodule

// File: rtl/am9513_ctx_bank.sv
// am9513_ctx_bank: per-context state bank for the Am9513 accelerator.
// Each context holds a rounding mode, sticky IEEE flags, scalar and vector
// register files and a legacy LIFO stack. A multi-cycle clear engine zeroes
// one register pair per cycle so a context can be recycled at runtime.
// Optional feature macro: AM9513_CTX_DIRTY_EN adds a per-context dirty bit
// (dirty_rdata output, dirty_clr_we input).
// Ports:
//   clk, rst_n                     : clock, async active-low reset
//   ctx_sel, rf_index              : context / register selection
//   rm_rdata .. stack_full         : combinational reads of ctx_sel
//   rm_we .. vec_wdata             : writes, applied at the next clk
//   push, push_data, pop           : stack operations
//   ovf_pulse, unf_pulse           : registered stack overflow / underflow
//   clr_req, clr_ctx               : clear request from the context manager
//   clr_busy, clr_done, clr_err    : clear engine status
module am9513_ctx_bank
  import carbon_arch_pkg::*;
  import am9513_pkg::*;
#(
  parameter int NUM_CONTEXTS = 64,
  parameter int NUM_REGS     = 16,
  parameter int REG_W        = 64,
  parameter int VEC_W        = 128,
  parameter int STACK_DEPTH  = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [15:0]                        ctx_sel,
  input  logic [$clog2(NUM_REGS)-1:0]        rf_index,
  output logic [1:0]                         rm_rdata,
  output logic [AM9513_NUM_FLAGS-1:0]        flags_rdata,
  output logic [REG_W-1:0]                   rf_rdata,
  output logic [VEC_W-1:0]                   vec_rdata,
  output logic [REG_W-1:0]                   stack_top,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
  output logic                               stack_empty,
  output logic                               stack_full,
  input  logic                               rm_we,
  input  logic [1:0]                         rm_wdata,
  input  logic                               flags_or_we,
  input  logic [AM9513_NUM_FLAGS-1:0]        flags_or,
  input  logic                               flags_clr_we,
  input  logic [AM9513_NUM_FLAGS-1:0]        flags_clr,
  input  logic                               rf_we,
  input  logic [REG_W-1:0]                   rf_wdata,
  input  logic                               vec_we,
  input  logic [VEC_W-1:0]                   vec_wdata,
  input  logic                               push,
  input  logic [REG_W-1:0]                   push_data,
  input  logic                               pop,
  output logic                               ovf_pulse,
  output logic                               unf_pulse,
  input  logic                               clr_req,
  input  logic [15:0]                        clr_ctx,
  output logic                               clr_busy,
  output logic                               clr_done,
  output logic                               clr_err
`ifdef AM9513_CTX_DIRTY_EN
  ,
  output logic                               dirty_rdata,
  input  logic                               dirty_clr_we
`endif
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int SP_W   = $clog2(STACK_DEPTH + 1);
  localparam int ADDR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CIDX_W = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1;
  localparam int NF     = AM9513_NUM_FLAGS;

  logic [NUM_CONTEXTS-1:0][1:0]                        rm_q;
  logic [NUM_CONTEXTS-1:0][NF-1:0]                     flags_q;
  logic [NUM_CONTEXTS-1:0][NUM_REGS-1:0][REG_W-1:0]    rf_q;
  logic [NUM_CONTEXTS-1:0][NUM_REGS-1:0][VEC_W-1:0]    vec_q;
  logic [NUM_CONTEXTS-1:0][STACK_DEPTH-1:0][REG_W-1:0] stk_q;
  logic [NUM_CONTEXTS-1:0][SP_W-1:0]                   sp_q;

  clr_state_e        state_q, state_d;
  logic [CIDX_W-1:0] cctx_q, cctx_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              err_d;
  logic              clearing, clear_first;

  logic              sel_valid, clr_valid, sel_hit, accept;
  logic [CIDX_W-1:0] sel_idx;
  logic [SP_W-1:0]   sp_cur, sp_next;
  logic              st_full, st_empty, st_we, st_ovf, st_unf;
  logic [ADDR_W-1:0] st_addr;
  logic [NF-1:0]     flags_next;

  assign sel_valid   = int'(ctx_sel) < NUM_CONTEXTS;
  assign clr_valid   = int'(clr_ctx) < NUM_CONTEXTS;
  assign sel_idx     = sel_valid ? ctx_sel[CIDX_W-1:0] : '0;
  assign clearing    = (state_q == CLR_CLEAR);
  assign clear_first = clearing && (idx_q == '0);
  // The context under clear looks freshly reset and ignores the sequencer.
  assign sel_hit     = clearing && (sel_idx == cctx_q);
  assign accept      = sel_valid && !sel_hit;

  assign sp_cur   = sp_q[sel_idx];
  assign st_full  = (sp_cur == SP_W'(STACK_DEPTH));
  assign st_empty = (sp_cur == '0);

  am9513_ctx_stack #(
    .SP_W   (SP_W),
    .ADDR_W (ADDR_W)
  ) u_stack (
    .push    (push && accept),
    .pop     (pop && accept),
    .full    (st_full),
    .empty   (st_empty),
    .sp      (sp_cur),
    .sp_next (sp_next),
    .wr_en   (st_we),
    .wr_addr (st_addr),
    .ovf     (st_ovf),
    .unf     (st_unf)
  );

  always_comb begin
    flags_next = flags_q[sel_idx];
    if (flags_clr_we) flags_next = flags_next & ~flags_clr;
    if (flags_or_we)  flags_next = flags_next | flags_or;
  end

  always_comb begin
    rm_rdata    = CARBON_RND_RN;
    flags_rdata = '0;
    rf_rdata    = '0;
    vec_rdata   = '0;
    stack_top   = '0;
    stack_depth = '0;
    if (accept) begin
      rm_rdata    = rm_q[sel_idx];
      flags_rdata = flags_q[sel_idx];
      rf_rdata    = rf_q[sel_idx][rf_index];
      vec_rdata   = vec_q[sel_idx][rf_index];
      stack_depth = sp_cur;
      if (!st_empty) stack_top = stk_q[sel_idx][ADDR_W'(sp_cur - SP_W'(1))];
    end
  end

  assign stack_empty = (stack_depth == '0);
  assign stack_full  = (stack_depth == SP_W'(STACK_DEPTH));

  always_comb begin
    state_d  = state_q;
    cctx_d   = cctx_q;
    idx_d    = idx_q;
    err_d    = 1'b0;
    clr_busy = 1'b0;
    clr_done = 1'b0;
    case (state_q)
      CLR_CLEAR: begin
        clr_busy = 1'b1;
        err_d    = clr_req;
        idx_d    = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_REGS - 1)) state_d = CLR_DONE;
      end
      default: begin
        // DONE samples requests exactly like IDLE so clears can chain.
        clr_done = (state_q == CLR_DONE);
        state_d  = CLR_IDLE;
        if (clr_req) begin
          if (clr_valid) begin
            state_d = CLR_CLEAR;
            cctx_d  = clr_ctx[CIDX_W-1:0];
            idx_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    endcase
  end

  // ---- control register stage: FSM and status pulses ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLR_IDLE;
      cctx_q    <= '0;
      idx_q     <= '0;
      clr_err   <= 1'b0;
      ovf_pulse <= 1'b0;
      unf_pulse <= 1'b0;
    end else begin
      state_q   <= state_d;
      cctx_q    <= cctx_d;
      idx_q     <= idx_d;
      clr_err   <= err_d;
      ovf_pulse <= st_ovf;
      unf_pulse <= st_unf;
    end
  end

  // ---- context storage stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rm_q    <= {NUM_CONTEXTS{CARBON_RND_RN}};
      flags_q <= '0;
      rf_q    <= '0;
      vec_q   <= '0;
      stk_q   <= '0;
      sp_q    <= '0;
    end else begin
      if (accept) begin
        if (rm_we)                       rm_q[sel_idx]              <= rm_wdata;
        if (flags_or_we || flags_clr_we) flags_q[sel_idx]           <= flags_next;
        if (rf_we)                       rf_q[sel_idx][rf_index]    <= rf_wdata;
        if (vec_we)                      vec_q[sel_idx][rf_index]   <= vec_wdata;
        if (st_we)                       stk_q[sel_idx][st_addr]    <= push_data;
        sp_q[sel_idx] <= sp_next;
      end
      // accept is low for the clearing context, so these never collide.
      if (clearing) begin
        rf_q[cctx_q][idx_q]  <= '0;
        vec_q[cctx_q][idx_q] <= '0;
        if (clear_first) begin
          rm_q[cctx_q]    <= CARBON_RND_RN;
          flags_q[cctx_q] <= '0;
          sp_q[cctx_q]    <= '0;
        end
      end
    end
  end

`ifdef AM9513_CTX_DIRTY_EN
  logic [NUM_CONTEXTS-1:0] dirty_q;
  logic                    any_op;

  assign any_op      = rm_we | flags_or_we | flags_clr_we | rf_we | vec_we | push | pop;
  assign dirty_rdata = accept && dirty_q[sel_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dirty_q <= '0;
    end else begin
      if (clear_first) dirty_q[cctx_q] <= 1'b0;
      // Set is evaluated last so it wins over a same-cycle clear.
      if (accept && dirty_clr_we) dirty_q[sel_idx] <= 1'b0;
      if (accept && any_op)       dirty_q[sel_idx] <= 1'b1;
    end
  end
`endif

endmodule
